// File: rtl/vu_pwm_capture_if.sv
// vu_pwm_capture_if: signal bundle between the VU PWM capture block and its user.
// Ports: enable, pwm_in (user -> capture); level, level_valid, peak, stuck_high (capture -> user).
// Modports: master = user side, slave = capture block.
interface vu_pwm_capture_if #(
    parameter int LEVEL_W = 7
);
    logic               enable;
    logic               pwm_in;
    logic [LEVEL_W-1:0] level;
    logic               level_valid;
    logic [LEVEL_W-1:0] peak;
    logic               stuck_high;

    modport master (output enable, pwm_in, input level, level_valid, peak, stuck_high);
    modport slave  (input enable, pwm_in, output level, level_valid, peak, stuck_high);
endinterface

// File: rtl/vu_pwm_capture.sv
// vu_pwm_capture: measures VU PWM high time per frame and keeps a decaying peak-hold.
// Ports: clk, reset (sync, active-high); bus.slave carries enable, pwm_in (async),
// level, level_valid (1-clk strobe), peak, stuck_high.
module vu_pwm_capture #(
    parameter int TICK_DIV     = 64,
    parameter int LEVEL_W      = 7,
    parameter int DECAY_FRAMES = 32
) (
    input  logic          clk,
    input  logic          reset,
    vu_pwm_capture_if.slave bus
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW = DECAY_FRAMES > 1 ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [TW-1:0]      TMAX = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]      DMAX = DW'(DECAY_FRAMES - 1);
    localparam logic [LEVEL_W-1:0] FMAX = '1;
    localparam logic [LEVEL_W-1:0] ONE  = LEVEL_W'(1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t             state;
    logic               pwm_m, pwm_s;
    logic [TW-1:0]      tick_cnt;
    logic [DW-1:0]      decay_cnt;
    logic [LEVEL_W-1:0] high_cnt, low_cnt, level, peak;
    logic               level_valid, stuck_high;
    logic               tick;

    assign tick            = tick_cnt == TMAX;
    assign bus.level       = level;
    assign bus.level_valid = level_valid;
    assign bus.peak        = peak;
    assign bus.stuck_high  = stuck_high;

    // free-running synchronizer, deliberately outside reset/enable
    always_ff @(posedge clk) begin
        pwm_m <= bus.pwm_in;
        pwm_s <= pwm_m;
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            decay_cnt   <= '0;
            level       <= '0;
            level_valid <= 1'b0;
            peak        <= '0;
            stuck_high  <= 1'b0;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            level_valid <= 1'b0;
            // peak tracks the level registered alongside the previous strobe
            if (level_valid) begin
                if (level >= peak) begin
                    peak      <= level;
                    decay_cnt <= '0;
                end else if (decay_cnt == DMAX) begin
                    if (peak != '0) peak <= peak - 1'b1;
                    decay_cnt <= '0;
                end else begin
                    decay_cnt <= decay_cnt + 1'b1;
                end
            end
            if (tick) begin
                case (state)
                    IDLE: begin
                        // wait for a low sample so a pulse is never measured mid-way
                        if (!pwm_s) begin
                            state   <= LOW;
                            low_cnt <= ONE;
                        end
                    end
                    LOW: begin
                        if (pwm_s) begin
                            state    <= HIGH;
                            high_cnt <= ONE;
                            low_cnt  <= '0;
                        end else if (low_cnt == FMAX) begin
                            level       <= '0;
                            level_valid <= 1'b1;
                            low_cnt     <= '0;
                        end else begin
                            low_cnt <= low_cnt + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (!pwm_s) begin
                            level       <= high_cnt;
                            level_valid <= 1'b1;
                            stuck_high  <= 1'b0;
                            state       <= LOW;
                            low_cnt     <= ONE;
                        end else if (high_cnt == FMAX) begin
                            level       <= FMAX;
                            level_valid <= 1'b1;
                            stuck_high  <= 1'b1;
                            high_cnt    <= '0;
                        end else begin
                            high_cnt <= high_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vu_pwm_capture.sv
// tb_vu_pwm_capture: table-driven PWM frames with an emit scoreboard and peak model.
module tb_vu_pwm_capture;
    localparam int TD = 4;

    typedef struct {
        logic       val;
        int         ticks;
        logic       emit;
        logic [6:0] lvl;
        logic       stuck;
        int         gap;
    } row_t;

    typedef struct {
        logic [6:0] lvl;
        logic       stuck;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t q[$];
    row_t tbl[12];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_v = -1;
    int   m_peak, m_dec, exp_peak;
    bit   pend;

    vu_pwm_capture_if #(.LEVEL_W(7)) bus ();
    vu_pwm_capture #(.TICK_DIV(TD), .LEVEL_W(7), .DECAY_FRAMES(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run(input logic v, input int ticks);
        bus.pwm_in = v;
        repeat (ticks * TD) @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset || !bus.enable) begin
                m_peak = 0;
                m_dec  = 0;
                pend   = 0;
                last_v = -1;
            end
            if (pend) begin
                check("peak", int'(bus.peak), exp_peak);
                pend = 0;
            end
            if (bus.level_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got level %0d, expected no strobe (cycle %0d)", bus.level, cyc);
                end else begin
                    e = q.pop_front();
                    check("level", int'(bus.level), int'(e.lvl));
                    check("stuck_high", int'(bus.stuck_high), int'(e.stuck));
                    if (e.gap != 0) check("valid_gap", cyc - last_v, e.gap * TD);
                    if (int'(e.lvl) >= m_peak) begin
                        m_peak = int'(e.lvl);
                        m_dec  = 0;
                    end else if (m_dec == 31) begin
                        if (m_peak > 0) m_peak--;
                        m_dec = 0;
                    end else begin
                        m_dec++;
                    end
                    exp_peak = m_peak;
                    pend = 1;
                end
                last_v = cyc;
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0,  88, 1'b0, 7'd0,   1'b0, 0};
        tbl[1]  = '{1'b1,  40, 1'b1, 7'd40,  1'b0, 0};
        tbl[2]  = '{1'b0,  88, 1'b0, 7'd0,   1'b0, 0};
        tbl[3]  = '{1'b1,  40, 1'b1, 7'd40,  1'b0, 128};
        tbl[4]  = '{1'b0,  88, 1'b0, 7'd0,   1'b0, 0};
        tbl[5]  = '{1'b1,  40, 1'b1, 7'd40,  1'b0, 128};
        tbl[6]  = '{1'b0, 128, 1'b1, 7'd0,   1'b0, 127};
        tbl[7]  = '{1'b0, 128, 1'b1, 7'd0,   1'b0, 128};
        tbl[8]  = '{1'b1, 128, 1'b1, 7'd127, 1'b1, 128};
        tbl[9]  = '{1'b1, 128, 1'b1, 7'd127, 1'b1, 128};
        tbl[10] = '{1'b1,  72, 1'b1, 7'd72,  1'b0, 73};
        tbl[11] = '{1'b0,  88, 1'b0, 7'd0,   1'b0, 0};

        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.pwm_in = 1'b1;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check("reset_outs", {bus.level_valid, bus.stuck_high, bus.level, bus.peak}, 0);
        bus.enable = 1'b1;
        run(1'b0, 130);
        check("reset_prio_outs", {bus.level_valid, bus.stuck_high, bus.level, bus.peak}, 0);
        run(1'b1, 10);
        reset = 1'b0;
        run(1'b1, 150);
        check("idle_high_outs", {bus.level_valid, bus.stuck_high, bus.level, bus.peak}, 0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].emit) q.push_back('{tbl[i].lvl, tbl[i].stuck, tbl[i].gap});
            run(tbl[i].val, tbl[i].ticks);
        end

        run(1'b1, 20);
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("disabled_outs", {bus.level_valid, bus.stuck_high, bus.level, bus.peak}, 0);
        end
        bus.enable = 1'b1;
        run(1'b1, 30);
        run(1'b0, 50);
        q.push_back('{7'd100, 1'b0, 0});
        run(1'b1, 100);
        run(1'b0, 28);
        check("peak_100", int'(bus.peak), 100);
        for (int k = 1; k <= 64; k++) begin
            q.push_back('{7'd20, 1'b0, k == 1 ? 48 : 128});
            run(1'b1, 20);
            run(1'b0, 108);
            if (k == 32) check("peak_after_32", int'(bus.peak), 99);
            if (k == 64) check("peak_after_64", int'(bus.peak), 98);
        end
        run(1'b0, 10);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_valid: got no strobe, expected level %0d", e.lvl);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
